// File: rtl/mul_pkg.sv
// Shared encodings for the HI/LO multiply sequencer: EX op codes, FSM states
// and the default multiplier response timeout.
package mul_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MTHI  = 3'd3,
    OP_MTLO  = 3'd4,
    OP_MFHI  = 3'd5,
    OP_MFLO  = 3'd6,
    OP_RSVD  = 3'd7
  } ex_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } mul_state_e;

  localparam int TIMEOUT_DEFAULT = 4;

  // True for every op that touches HI/LO and therefore must wait out a busy multiply.
  function automatic logic is_hilo_op(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd6);
  endfunction

endpackage

// File: rtl/hilo_regfile.sv
// Architectural HI/LO pair: MT write port, product write port and MF read mux.
module hilo_regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mt_hi_we,
  input  logic        mt_lo_we,
  input  logic [31:0] mt_data,
  input  logic        prod_we,
  input  logic [63:0] prod_data,
  input  logic        rd_en,
  input  logic        rd_hi,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // The FSM never raises an MT write and a product write together; product wins anyway.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (prod_we) begin
      hi_d = prod_data[63:32];
      lo_d = prod_data[31:0];
    end else begin
      if (mt_hi_we) hi_d = mt_data;
      if (mt_lo_we) lo_d = mt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign rd_data = rd_en ? (rd_hi ? hi_q : lo_q) : 32'd0;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// EX-stage sequencer for the two-cycle multiplier: issues MULT/MULTU, captures
// the product into HI/LO, stalls dependent HI/LO ops and watches for a dead multiplier.
module mul_hilo_ctrl
  import mul_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        flush,
  output logic        ex_stall,
  output logic [31:0] ex_result,
  output logic        mul_en,
  output logic        mul_sig,
  output logic [31:0] mul_s1,
  output logic [31:0] mul_s2,
  input  logic [63:0] mul_c,
  input  logic        mul_enable,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mul_state_e  state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        mul_en_q, mul_en_d;

  logic mt_hi_we, mt_lo_we, prod_we;
  logic idle_op, rd_en, rd_hi;

  assign idle_op = (state_q == ST_IDLE) && ex_valid && !flush;

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    mt_hi_we = 1'b0;
    mt_lo_we = 1'b0;
    prod_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (idle_op) begin
          if ((ex_op == OP_MULT) || (ex_op == OP_MULTU)) begin
            op_a_d  = ex_rs;
            op_b_d  = ex_rt;
            sig_d   = (ex_op == OP_MULT);
            state_d = ST_ISSUE;
          end
          mt_hi_we = (ex_op == OP_MTHI);
          mt_lo_we = (ex_op == OP_MTLO);
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = flush ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        // Flush beats a product landing on the same edge.
        if (flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (mul_enable) begin
          prod_we = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    mul_en_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      sig_q    <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      mul_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      mul_en_q <= mul_en_d;
    end
  end

  assign rd_en = idle_op && ((ex_op == OP_MFHI) || (ex_op == OP_MFLO));
  assign rd_hi = (ex_op == OP_MFHI);

  hilo_regfile u_hilo (
    .clk       (clk),
    .resetn    (resetn),
    .mt_hi_we  (mt_hi_we),
    .mt_lo_we  (mt_lo_we),
    .mt_data   (ex_rs),
    .prod_we   (prod_we),
    .prod_data (mul_c),
    .rd_en     (rd_en),
    .rd_hi     (rd_hi),
    .rd_data   (ex_result),
    .hi        (hi),
    .lo        (lo)
  );

  assign busy     = (state_q != ST_IDLE);
  assign ex_stall = ex_valid && is_hilo_op(ex_op) && busy;
  assign mul_en   = mul_en_q;
  assign mul_sig  = sig_q;
  assign mul_s1   = op_a_q;
  assign mul_s2   = op_b_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl; inputs change on the falling edge and
// outputs are checked 1 ns later, so each check sees one full cycle's state.
module tb_mul_hilo_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_rs, ex_rt;
  logic        flush;
  logic        ex_stall;
  logic [31:0] ex_result;
  logic        mul_en, mul_sig;
  logic [31:0] mul_s1, mul_s2;
  logic [63:0] mul_c;
  logic        mul_enable;
  logic [31:0] hi, lo;
  logic        busy, err;

  int checks = 0;
  int fails  = 0;

  mul_hilo_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush), .ex_stall(ex_stall),
    .ex_result(ex_result), .mul_en(mul_en), .mul_sig(mul_sig),
    .mul_s1(mul_s1), .mul_s2(mul_s2), .mul_c(mul_c), .mul_enable(mul_enable),
    .hi(hi), .lo(lo), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic next();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    ex_valid = v; ex_op = op; ex_rs = rs; ex_rt = rt;
  endtask

  task automatic respond(input logic en, input logic [63:0] c);
    mul_enable = en; mul_c = c;
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    respond(1'b0, 64'd0);
    next(); next(); #1;
    checks++; if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
    checks++; if ({busy, err, mul_en, ex_stall} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b want 0000", {busy, err, mul_en, ex_stall}); end
    checks++; if ({mul_s1, mul_s2, mul_sig} !== 65'd0) begin fails++; $display("FAIL reset_operands: got %h want 0", {mul_s1, mul_s2, mul_sig}); end
    next(); resetn = 1'b1;
    $display("reset: hi=%h lo=%h busy=%b err=%b", hi, lo, busy, err);
  endtask

  task automatic test_mult_signed_unsigned();
    for (int k = 0; k < 2; k++) begin
      logic [63:0] prod;
      prod = (k == 0) ? 64'hFFFFFFFF_FFFFFFFE : 64'h00000001_FFFFFFFE;
      next(); drive(1'b1, (k == 0) ? 3'd1 : 3'd2, 32'hFFFFFFFF, 32'd2); #1;
      checks++; if (ex_stall !== 1'b0) begin fails++; $display("FAIL mult_accept_stall[%0d]: got %b want 0", k, ex_stall); end
      next(); drive(1'b0, 3'd0, 32'd0, 32'd0); #1;
      checks++; if ({mul_en, busy} !== 2'b11) begin fails++; $display("FAIL issue_en[%0d]: got %b want 11", k, {mul_en, busy}); end
      checks++; if (mul_sig !== (k == 0)) begin fails++; $display("FAIL issue_sig[%0d]: got %b want %b", k, mul_sig, k == 0); end
      checks++; if ({mul_s1, mul_s2} !== {32'hFFFFFFFF, 32'd2}) begin fails++; $display("FAIL issue_ops[%0d]: got %h %h want ffffffff 00000002", k, mul_s1, mul_s2); end
      next(); respond(1'b1, prod); #1;
      checks++; if ({mul_en, busy} !== 2'b01) begin fails++; $display("FAIL wait_en[%0d]: got %b want 01", k, {mul_en, busy}); end
      next(); respond(1'b0, 64'd0); #1;
      checks++; if ({hi, lo} !== prod) begin fails++; $display("FAIL mult_result[%0d]: got %h want %h", k, {hi, lo}, prod); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mult_done_busy[%0d]: got %b want 0", k, busy); end
      $display("mult k=%0d: hi=%h lo=%h", k, hi, lo);
    end
  endtask

  task automatic test_stall();
    next(); drive(1'b1, 3'd1, 32'h00010000, 32'h00010000);
    next(); drive(1'b1, 3'd6, 32'd0, 32'd0); #1;
    checks++; if ({ex_stall, ex_result} !== {1'b1, 32'd0}) begin fails++; $display("FAIL stall_c1: got %b/%h want 1/0", ex_stall, ex_result); end
    next(); respond(1'b1, 64'h00000001_00000000); #1;
    checks++; if (ex_stall !== 1'b1) begin fails++; $display("FAIL stall_c2: got %b want 1", ex_stall); end
    next(); respond(1'b0, 64'd0); #1;
    checks++; if ({ex_stall, lo, ex_result} !== {1'b0, 32'd0, 32'd0}) begin fails++; $display("FAIL stall_mflo: got %b/%h/%h want 0/0/0", ex_stall, lo, ex_result); end
    next(); drive(1'b1, 3'd5, 32'd0, 32'd0); #1;
    checks++; if (ex_result !== 32'h00000001) begin fails++; $display("FAIL stall_mfhi: got %h want 00000001", ex_result); end
    next(); drive(1'b0, 3'd5, 32'd0, 32'd0); #1;
    checks++; if (ex_result !== 32'd0) begin fails++; $display("FAIL mf_invalid_zero: got %h want 0", ex_result); end
    $display("stall: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_mt_mf();
    next(); drive(1'b1, 3'd3, 32'h00001234, 32'd0); #1;
    checks++; if (ex_stall !== 1'b0) begin fails++; $display("FAIL mthi_stall: got %b want 0", ex_stall); end
    next(); drive(1'b1, 3'd5, 32'd0, 32'd0); #1;
    checks++; if ({ex_stall, ex_result} !== {1'b0, 32'h00001234}) begin fails++; $display("FAIL mfhi_after_mthi: got %b/%h want 0/00001234", ex_stall, ex_result); end
    next(); drive(1'b1, 3'd4, 32'h00005678, 32'd0);
    next(); drive(1'b1, 3'd6, 32'd0, 32'd0); #1;
    checks++; if ({ex_result, hi} !== {32'h00005678, 32'h00001234}) begin fails++; $display("FAIL mflo_after_mtlo: got %h/%h want 00005678/00001234", ex_result, hi); end
    $display("mt_mf: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_flush();
    next(); drive(1'b1, 3'd1, 32'd3, 32'd5);
    next(); drive(1'b0, 3'd0, 32'd0, 32'd0);
    next(); flush = 1'b1; respond(1'b1, 64'd15);
    next(); flush = 1'b0; respond(1'b0, 64'd0); #1;
    checks++; if ({busy, hi, lo} !== {1'b0, 32'h00001234, 32'h00005678}) begin fails++; $display("FAIL flush_wait: got %b/%h/%h want 0/00001234/00005678", busy, hi, lo); end
    drive(1'b1, 3'd3, 32'h0000DEAD, 32'd0); flush = 1'b1;
    next(); drive(1'b1, 3'd1, 32'd3, 32'd5);
    next(); flush = 1'b0; drive(1'b0, 3'd0, 32'd0, 32'd0); #1;
    checks++; if ({busy, hi} !== {1'b0, 32'h00001234}) begin fails++; $display("FAIL flush_idle: got %b/%h want 0/00001234", busy, hi); end
    $display("flush: hi=%h lo=%h busy=%b", hi, lo, busy);
  endtask

  task automatic test_timeout();
    next(); drive(1'b1, 3'd1, 32'd7, 32'd9);
    next(); drive(1'b0, 3'd0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) next();
    #1;
    checks++; if ({busy, err} !== 2'b10) begin fails++; $display("FAIL timeout_wait4: got %b want 10", {busy, err}); end
    next(); respond(1'b1, 64'hAAAAAAAA_BBBBBBBB); #1;
    checks++; if ({busy, err, hi, lo} !== {2'b01, 32'h00001234, 32'h00005678}) begin fails++; $display("FAIL timeout_err: got %b/%h/%h want 01/00001234/00005678", {busy, err}, hi, lo); end
    next(); respond(1'b0, 64'd0); #1;
    checks++; if ({err, hi, lo} !== {1'b1, 32'h00001234, 32'h00005678}) begin fails++; $display("FAIL idle_enable_ignored: got %b/%h/%h want 1/00001234/00005678", err, hi, lo); end
    $display("timeout: err=%b busy=%b", err, busy);
  endtask

  task automatic test_reset_mid();
    next(); drive(1'b1, 3'd1, 32'h11, 32'h22);
    next(); drive(1'b0, 3'd0, 32'd0, 32'd0); resetn = 1'b0;
    next(); resetn = 1'b1; #1;
    checks++; if ({mul_en, busy, err, mul_sig, hi, lo, mul_s1} !== {4'b0000, 96'd0}) begin fails++; $display("FAIL reset_mid: got %b/%h/%h/%h want 0000/0/0/0", {mul_en, busy, err, mul_sig}, hi, lo, mul_s1); end
    drive(1'b1, 3'd2, 32'd6, 32'd7);
    next(); drive(1'b0, 3'd0, 32'd0, 32'd0); #1;
    checks++; if ({mul_en, mul_s1, mul_s2} !== {1'b1, 32'd6, 32'd7}) begin fails++; $display("FAIL post_reset_issue: got %b/%h/%h want 1/6/7", mul_en, mul_s1, mul_s2); end
    next(); respond(1'b1, 64'd42);
    next(); respond(1'b0, 64'd0); #1;
    checks++; if ({busy, hi, lo} !== {1'b0, 32'd0, 32'd42}) begin fails++; $display("FAIL post_reset_mult: got %b/%h/%h want 0/0/2a", busy, hi, lo); end
    $display("reset_mid: hi=%h lo=%h", hi, lo);
  endtask

  initial begin
    test_reset();
    test_mult_signed_unsigned();
    test_stall();
    test_mt_mf();
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
